// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out shifter.
// State encodings are fixed so older code keyed on the raw values still lines up.
package piso_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'b00;
    localparam state_t SHIFT = 2'b01;
    localparam state_t DONE  = 2'b10;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit position counter for one serialized word.
// Raises last on the final bit position and holds there rather than wrapping.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !last) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == TERMINAL);

endmodule

// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shifter with valid/ready load handshake.
// Each word occupies WIDTH valid cycles, followed by a single done cycle.
module piso_shifter
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             accept;
    logic             last;

    assign load_ready = (state != SHIFT);
    assign busy       = (state == SHIFT);
    assign accept     = load_valid && load_ready;

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (busy),
        .last   (last)
    );

    // The first bit goes straight from load_data to ser_out on the accept edge,
    // so the register keeps only the bits still to be sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state     <= SHIFT;
                        ser_valid <= 1'b1;
                        if (MSB_FIRST) begin
                            ser_out <= load_data[WIDTH-1];
                            shreg   <= load_data << 1;
                        end else begin
                            ser_out <= load_data[0];
                            shreg   <= load_data >> 1;
                        end
                    end else begin
                        state     <= IDLE;
                        ser_out   <= 1'b0;
                        ser_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (last) begin
                        state     <= DONE;
                        ser_out   <= 1'b0;
                        ser_valid <= 1'b0;
                        done      <= 1'b1;
                    end else if (MSB_FIRST) begin
                        ser_out <= shreg[WIDTH-1];
                        shreg   <= shreg << 1;
                    end else begin
                        ser_out <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ser_out   <= 1'b0;
                    ser_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
